// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, arbiter state encoding and round-robin index helper.
package uart_pkg;

  localparam int unsigned DBIT = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_BUSY
  } arb_state_t;

  // Candidate index k steps after 'last', wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned last, input int unsigned k,
                                          input int unsigned n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester and uart_tx-side signals around the shared transmitter.
// Optional req_lock vector present only when UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();
  import uart_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*DBIT-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N_REQ-1:0]      req_lock;
`endif
  logic                  s_tick;
  logic                  tx_done_tick;
  logic                  tx_start;
  logic [DBIT-1:0]       tx_din;
  logic [IDX_W-1:0]      grant_id;
  logic                  busy;

`ifdef UART_TX_ARB_LOCK_EN
  modport master (
    output req_valid, req_data, req_lock, s_tick, tx_done_tick,
    input  req_ready, tx_start, tx_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_lock, s_tick, tx_done_tick,
    output req_ready, tx_start, tx_din, grant_id, busy
  );
`else
  modport master (
    output req_valid, req_data, s_tick, tx_done_tick,
    input  req_ready, tx_start, tx_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, s_tick, tx_done_tick,
    output req_ready, tx_start, tx_din, grant_id, busy
  );
`endif

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping around.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  // Walk from the farthest candidate back to the nearest so the nearest one wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      w_cand = IDX_W'(rr_next(32'(i_last), unsigned'(k), N_REQ));
      if (i_req[w_cand]) begin
        o_onehot         = '0;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
        o_any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Define UART_TX_ARB_LOCK_EN to let the current owner lock the transmitter across frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input logic              clk,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be in 2..16");
  end

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant_id;
  logic [DBIT-1:0]  r_data;
  logic             r_tx_start;
  logic             r_busy;

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

`ifdef UART_TX_ARB_LOCK_EN
  logic             r_lock_hold;
  logic             w_locked;
  logic [N_REQ-1:0] w_owner_oh;

  assign w_locked = r_lock_hold & bus.req_lock[r_grant_id];

  // While locked only the previous owner may compete.
  always_comb begin
    w_owner_oh             = '0;
    w_owner_oh[r_grant_id] = 1'b1;
    w_req                  = w_locked ? (bus.req_valid & w_owner_oh) : bus.req_valid;
  end
`else
  assign w_req = bus.req_valid;
`endif

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req    (w_req),
    .i_last   (r_grant_id),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Zero-latency acceptance strobe; held low while in reset.
  assign bus.req_ready = (reset_n && (r_state == ARB_IDLE)) ? w_onehot : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ARB_IDLE;
      r_grant_id  <= IDX_W'(N_REQ - 1);
      r_data      <= '0;
      r_tx_start  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_data     <= bus.req_data[32'(w_idx)*DBIT +: DBIT];
            r_grant_id <= w_idx;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ARB_START;
          end
`ifdef UART_TX_ARB_LOCK_EN
          if (w_any || !bus.req_lock[r_grant_id]) begin
            r_lock_hold <= 1'b0;
          end
`endif
        end
        ARB_START: begin
          if (bus.s_tick) begin
            r_tx_start <= 1'b0;
            r_state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (bus.tx_done_tick) begin
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            r_lock_hold <= bus.req_lock[r_grant_id];
`endif
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start = r_tx_start;
  assign bus.tx_din   = r_data;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx stand-in.
// Lock scenario compiled in only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned DONE_CYC = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ (N_REQ)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q[$];          // {grant_id, byte} in expected transmit order
  logic [8:0]  drv_q[N_REQ][$];   // per requester {lock, byte}
  logic [N_REQ-1:0] xfer = '0;
  logic [9:0]  e;

  bit          tick_en    = 1'b0;
  bit          tick_auto  = 1'b0;
  bit          man_tick   = 1'b0;
  bit          man_done   = 1'b0;
  bit          model_done = 1'b0;
  bit          prev_start = 1'b0;
  int unsigned tick_cnt   = 0;
  int unsigned model_cnt  = 0;

  assign bus.s_tick       = tick_auto | man_tick;
  assign bus.tx_done_tick = model_done | man_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit drivers_empty();
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (drv_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !bus.busy && drivers_empty()) done = 1'b1;
    end
    check({name, " drained"}, 32'(done), 32'(1));
  endtask

  // Requester drivers: present head of queue, retire it after an accepted handshake.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef UART_TX_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (xfer[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[i*8 +: 8] = drv_q[i][0][7:0];
`ifdef UART_TX_ARB_LOCK_EN
          bus.req_lock[i]        = drv_q[i][0][8];
`endif
        end else begin
          bus.req_valid[i] = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
          bus.req_lock[i]  = 1'b0;
`endif
        end
      end
      #1;
      xfer = bus.req_valid & bus.req_ready;
    end
  end

  // Monitor + uart_tx stand-in: a falling tx_start with busy high marks a captured frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        model_cnt  = 0;
        model_done = 1'b0;
        prev_start = 1'b0;
        tick_cnt   = 0;
        tick_auto  = 1'b0;
      end else begin
        if (model_done) begin
          model_done = 1'b0;
        end else if (model_cnt > 0) begin
          model_cnt--;
          if (model_cnt == 0) model_done = 1'b1;
        end
        if (prev_start && !bus.tx_start && bus.busy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected frame: byte 0x%0h grant %0d, expected none",
                     bus.tx_din, bus.grant_id);
          end else begin
            e = exp_q.pop_front();
            check("frame byte", 32'(bus.tx_din), 32'(e[7:0]));
            check("frame grant", 32'(bus.grant_id), 32'(e[9:8]));
          end
          model_cnt = DONE_CYC;
        end
        prev_start = bus.tx_start;
        if (tick_en) begin
          tick_cnt  = (tick_cnt + 1) % 4;
          tick_auto = (tick_cnt == 0);
        end else begin
          tick_auto = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #2;
    check("reset tx_start", 32'(bus.tx_start), 32'(0));
    check("reset busy", 32'(bus.busy), 32'(0));
    check("reset grant_id", 32'(bus.grant_id), 32'(3));
    check("reset req_ready", 32'(bus.req_ready), 32'(0));
    check("reset tx_din", 32'(bus.tx_din), 32'(0));

    // Single byte from requester 0 with hand-driven ticks.
    exp_q.push_back({2'd0, 8'h55});
    drv_q[0].push_back({1'b0, 8'h55});
    @(negedge clk);
    #2;
    check("t1 req_ready", 32'(bus.req_ready), 32'(4'b0001));
    check("t1 idle tx_start", 32'(bus.tx_start), 32'(0));
    @(negedge clk);
    #2;
    check("t1 tx_start", 32'(bus.tx_start), 32'(1));
    check("t1 tx_din", 32'(bus.tx_din), 32'(8'h55));
    check("t1 busy", 32'(bus.busy), 32'(1));
    check("t1 ready low", 32'(bus.req_ready), 32'(0));
    check("t1 grant_id", 32'(bus.grant_id), 32'(0));
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    #2;
    check("done in START ignored", 32'(bus.tx_start), 32'(1));
    repeat (2) @(negedge clk);
    #2;
    check("tx_start held", 32'(bus.tx_start), 32'(1));
    @(negedge clk);
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
    #2;
    check("t1 tx_start drop", 32'(bus.tx_start), 32'(0));
    check("t1 busy in BUSY", 32'(bus.busy), 32'(1));
    wait_drain(100, "t1");
    check("t1 busy end", 32'(bus.busy), 32'(0));

    // tx_done_tick in IDLE is ignored.
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    #2;
    check("done in IDLE busy", 32'(bus.busy), 32'(0));
    check("done in IDLE tx_start", 32'(bus.tx_start), 32'(0));

    tick_en = 1'b1;

    // Reset while BUSY drops everything back to reset values.
    exp_q.push_back({2'd2, 8'hA5});
    drv_q[2].push_back({1'b0, 8'hA5});
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      #2;
      if (bus.busy && !bus.tx_start) reached = 1'b1;
    end
    check("t5 reached BUSY", 32'(reached), 32'(1));
    reset_n = 1'b0;
    #1;
    check("t5 async tx_start", 32'(bus.tx_start), 32'(0));
    check("t5 async busy", 32'(bus.busy), 32'(0));
    check("t5 async grant_id", 32'(bus.grant_id), 32'(3));
    check("t5 async req_ready", 32'(bus.req_ready), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("t5 frame consumed", 32'(exp_q.size()), 32'(0));

    // All four valid: order 0,1,2,3,0 starting from post-reset priority.
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12});
    exp_q.push_back({2'd3, 8'h13});
    exp_q.push_back({2'd0, 8'h10});
    drv_q[0].push_back({1'b0, 8'h10});
    drv_q[0].push_back({1'b0, 8'h10});
    drv_q[1].push_back({1'b0, 8'h11});
    drv_q[2].push_back({1'b0, 8'h12});
    drv_q[3].push_back({1'b0, 8'h13});
    wait_drain(400, "t2");
    check("t2 final grant", 32'(bus.grant_id), 32'(0));

    // Bring grant to 2, then 0101 must wrap to 0 before 2.
    exp_q.push_back({2'd2, 8'h22});
    drv_q[2].push_back({1'b0, 8'h22});
    wait_drain(100, "t3a");
    check("t3 grant 2", 32'(bus.grant_id), 32'(2));
    exp_q.push_back({2'd0, 8'h30});
    exp_q.push_back({2'd2, 8'h32});
    drv_q[0].push_back({1'b0, 8'h30});
    drv_q[2].push_back({1'b0, 8'h32});
    wait_drain(200, "t3b");
    check("t3 final grant", 32'(bus.grant_id), 32'(2));

`ifdef UART_TX_ARB_LOCK_EN
    // From grant 3, requester 1 wins and keeps the line for three locked bytes.
    exp_q.push_back({2'd3, 8'h33});
    drv_q[3].push_back({1'b0, 8'h33});
    wait_drain(100, "t6a");
    exp_q.push_back({2'd1, 8'h41});
    exp_q.push_back({2'd1, 8'h42});
    exp_q.push_back({2'd1, 8'h43});
    exp_q.push_back({2'd3, 8'h4F});
    drv_q[1].push_back({1'b1, 8'h41});
    drv_q[1].push_back({1'b1, 8'h42});
    drv_q[1].push_back({1'b1, 8'h43});
    drv_q[3].push_back({1'b0, 8'h4F});
    wait_drain(400, "t6b");
    check("t6 final grant", 32'(bus.grant_id), 32'(3));
`endif

    repeat (3) @(negedge clk);
    check("scoreboard empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx serializer between N_REQ byte producers.
- Accepts one byte per valid/ready handshake and holds tx_start until uart_tx samples it on an s_tick.
- Waits for tx_done_tick before granting the next byte.
- Sits between the client logic (command responder, debug printer, ...) and the single uart_tx / baud_gen pair.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- IDX_W, $clog2(N_REQ), width of grant index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester byte-available flag.
- req_data  input  N_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  output  N_REQ  one-hot acceptance strobe; a byte transfers when valid & ready.
- s_tick  input  1  oversample tick from baud_gen, shared with uart_tx.
- tx_done_tick  input  1  from uart_tx; end of stop bit.
- tx_start  output  1  to uart_tx.
- tx_din  output  8  byte to uart_tx; stable while tx_start is high.
- grant_id  output  IDX_W  index of the current/last owner.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, tx_start=0, tx_din=0, req_ready=0, grant_id=N_REQ-1, busy=0, data_reg=0. Reset mid-frame drops the in-flight byte silently. The top level drives uart_tx reset from ~reset_n.
- Round-robin: search starts at grant_id+1 mod N_REQ and wraps. The first index with req_valid=1 wins. Immediately after reset, requester 0 has priority.
- IDLE:
  - If any req_valid, req_ready[winner]=1 combinationally this cycle (one-hot, zero latency).
  - On the next edge: data_reg<=req_data[winner], grant_id<=winner, go to START.
  - Otherwise stay in IDLE.
- START:
  - tx_start=1, tx_din=data_reg.
  - On a cycle with s_tick=1, uart_tx captures the byte; go to BUSY on that edge, and tx_start drops the next cycle.
  - No timeout.
- BUSY:
  - tx_start=0, tx_din holds data_reg.
  - On tx_done_tick=1, go to IDLE.
  - s_tick is ignored.
- req_ready is 0 in START and BUSY. Requesters must hold req_valid/req_data stable until ready.
- Minimum gap: after a done, one IDLE cycle, then START waits for the next s_tick.
- A tx_done_tick seen outside BUSY is ignored.
- req_valid for a non-winner stays pending; there is no starvation, since a requester waits at most N_REQ-1 frames.
- Simultaneous tx_done_tick and req_valid: done takes effect first (BUSY->IDLE); the new grant happens in the following IDLE cycle.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock [N_REQ].
  - On BUSY->IDLE, if req_lock[grant_id]=1, the next arbitration is restricted to grant_id; other requesters are not served.
  - If the owner has lock=1 but valid=0, the arbiter stays in IDLE holding the bus until valid rises or lock drops.
  - When lock drops, normal round-robin resumes from grant_id+1.
- When undefined: no req_lock port, pure per-byte round-robin.

Decomposition:
- Package uart_pkg:
  - typedef enum {ARB_IDLE, ARB_START, ARB_BUSY} arb_state_t.
  - localparam DBIT=8, shared with uart_tx.
- Sub-module rr_pick (pure combinational):
  - Inputs: req vector, last index.
  - Outputs: one-hot winner, winner index, any flag.
  - Reusable for future RX routing.
- The arbiter FSM stays in uart_tx_arbiter.

Test Plan:
- Reset, then req_valid=4'b0001 with data 8'h55: req_ready=0001 in the first cycle; tx_start rises next cycle with tx_din=8'h55 and holds until the first s_tick; busy=1 until tx_done_tick. The serial line decodes 0x55.
- req_valid=4'b1111 held, data 0x10..0x13 (one byte per requester): the transmitted order is 0x10,0x11,0x12,0x13,0x10; grant_id sequence is 0,1,2,3,0.
- After grant_id=2, req_valid=4'b0101: the next winner is 0 (wrap past 3), then 2.
- tx_done_tick pulsed while in IDLE and START: no state change; tx_start remains held in START.
- Assert reset_n=0 mid-BUSY: state=IDLE, tx_start=0, busy=0, grant_id=N_REQ-1 asynchronously. After release, requester 0 is served first.
- With UART_TX_ARB_LOCK_EN: requester 1 holds req_lock=1 and sends 3 bytes while requester 3 is valid. All 3 bytes from requester 1 go first, then requester 3 is granted once lock drops.
